// File: rtl/firmware_pkg.sv
// Constants, state encoding and header bounds check shared by the firmware
// loader and the firmware store model.
package firmware_pkg;

    localparam int         FIRMWARE_SIZE = 'h3000;
    localparam int         ADDR_W        = $clog2(FIRMWARE_SIZE);
    localparam logic [7:0] SYNC_BYTE     = 8'hA5;
    localparam int         FLAG_FINAL    = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLAGS,
        ST_ADDR_H,
        ST_ADDR_L,
        ST_LEN_H,
        ST_LEN_L,
        ST_DATA,
        ST_CSUM
    } state_t;

    // 17-bit arithmetic so that ADDR + LEN cannot wrap before the compare.
    function automatic logic header_ok(input logic [15:0] addr,
                                       input logic [15:0] len,
                                       input int          size);
        logic [16:0] size_w;
        logic [16:0] end_addr;
        size_w   = 17'(size);
        end_addr = {1'b0, addr} + {1'b0, len};
        return (len != 16'd0) && ({1'b0, addr} < size_w) && (end_addr <= size_w);
    endfunction

endpackage

// File: rtl/firmware_loader_if.sv
// Byte-stream input and firmware-store write port of the loader, plus its
// status outputs.
interface firmware_loader_if;
    import firmware_pkg::*;

    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [ADDR_W-1:0] wr_address;
    logic [7:0]        wr_data;
    logic              wr_en;
    logic              busy;
    logic              done;
    logic              err;
    logic              cpu_hold;

    modport master (
        input  rx_data, rx_valid,
        output rx_ready, wr_address, wr_data, wr_en, busy, done, err, cpu_hold
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ready, wr_address, wr_data, wr_en, busy, done, err, cpu_hold
    );

endinterface

// File: rtl/firmware_loader.sv
// Framed byte-stream firmware loader: writes payload straight into the store,
// checks a per-frame 8-bit checksum and releases the CPU after a good final frame.
//
// state    | meaning
// ST_IDLE  | hunting for SYNC_BYTE, other bytes discarded
// ST_FLAGS | expecting FLAGS byte
// ST_ADDR_H| expecting address high byte
// ST_ADDR_L| expecting address low byte
// ST_LEN_H | expecting length high byte
// ST_LEN_L | expecting length low byte, header bounds check here
// ST_DATA  | payload bytes, one write per byte
// ST_CSUM  | checksum byte, frame verdict
module firmware_loader #(
    parameter int         FIRMWARE_SIZE = firmware_pkg::FIRMWARE_SIZE,
    parameter logic [7:0] SYNC_BYTE     = firmware_pkg::SYNC_BYTE
) (
    input  logic                clk,
    input  logic                rst_n,
    firmware_loader_if.master   bus
);
    import firmware_pkg::*;

    state_t            state;
    state_t            state_nxt;

    logic              final_q;
    logic [7:0]        addr_h_q;
    logic [7:0]        addr_l_q;
    logic [7:0]        len_h_q;
    logic [7:0]        csum_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [15:0]       remain_q;

    logic              rx_ready_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_address_q;
    logic [7:0]        wr_data_q;
    logic              done_q;
    logic              err_q;
    logic              cpu_hold_q;

    logic              take;
    logic [15:0]       hdr_addr;
    logic [15:0]       hdr_len;
    logic [7:0]        csum_sum;

    logic              sync_seen;
    logic              hdr_accept;
    logic              hdr_reject;
    logic              data_write;
    logic              csum_good;
    logic              csum_bad;

    assign take     = bus.rx_valid && rx_ready_q;
    assign hdr_addr = {addr_h_q, addr_l_q};
    assign hdr_len  = {len_h_q, bus.rx_data};
    assign csum_sum = csum_q + bus.rx_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        sync_seen  = 1'b0;
        hdr_accept = 1'b0;
        hdr_reject = 1'b0;
        data_write = 1'b0;
        csum_good  = 1'b0;
        csum_bad   = 1'b0;
        if (take) begin
            case (state)
                ST_IDLE: begin
                    if (bus.rx_data == SYNC_BYTE) begin
                        sync_seen = 1'b1;
                        state_nxt = ST_FLAGS;
                    end
                end
                ST_FLAGS:  state_nxt = ST_ADDR_H;
                ST_ADDR_H: state_nxt = ST_ADDR_L;
                ST_ADDR_L: state_nxt = ST_LEN_H;
                ST_LEN_H:  state_nxt = ST_LEN_L;
                ST_LEN_L: begin
                    if (header_ok(hdr_addr, hdr_len, FIRMWARE_SIZE)) begin
                        hdr_accept = 1'b1;
                        state_nxt  = ST_DATA;
                    end else begin
                        hdr_reject = 1'b1;
                        state_nxt  = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    data_write = 1'b1;
                    if (remain_q == 16'd1) begin
                        state_nxt = ST_CSUM;
                    end
                end
                ST_CSUM: begin
                    if (csum_sum == 8'h00) begin
                        csum_good = 1'b1;
                    end else begin
                        csum_bad = 1'b1;
                    end
                    state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Header capture, checksum accumulation, write pointer and byte counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            final_q  <= 1'b0;
            addr_h_q <= 8'h00;
            addr_l_q <= 8'h00;
            len_h_q  <= 8'h00;
            csum_q   <= 8'h00;
            ptr_q    <= '0;
            remain_q <= 16'd0;
        end else begin
            if (sync_seen) begin
                csum_q <= 8'h00;
            end else if (take && state != ST_IDLE) begin
                csum_q <= csum_sum;
            end
            if (take && state == ST_FLAGS) begin
                final_q <= bus.rx_data[FLAG_FINAL];
            end
            if (take && state == ST_ADDR_H) begin
                addr_h_q <= bus.rx_data;
            end
            if (take && state == ST_ADDR_L) begin
                addr_l_q <= bus.rx_data;
            end
            if (take && state == ST_LEN_H) begin
                len_h_q <= bus.rx_data;
            end
            if (hdr_accept) begin
                ptr_q    <= hdr_addr[ADDR_W-1:0];
                remain_q <= hdr_len;
            end else if (data_write) begin
                ptr_q    <= ptr_q + 1'b1;
                remain_q <= remain_q - 16'd1;
            end
        end
    end

    // Registered outputs; cpu_hold can only return to 1 through reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ready_q   <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_address_q <= '0;
            wr_data_q    <= 8'h00;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            cpu_hold_q   <= 1'b1;
        end else begin
            rx_ready_q <= 1'b1;
            wr_en_q    <= data_write;
            if (data_write) begin
                wr_address_q <= ptr_q;
                wr_data_q    <= bus.rx_data;
            end
            done_q <= csum_good;
            if (sync_seen) begin
                err_q <= 1'b0;
            end else if (hdr_reject || csum_bad) begin
                err_q <= 1'b1;
            end
            if (csum_good && final_q) begin
                cpu_hold_q <= 1'b0;
            end
        end
    end

    assign bus.rx_ready   = rx_ready_q;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_address = wr_address_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.busy       = (state != ST_IDLE);
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.cpu_hold   = cpu_hold_q;

endmodule

// File: tb/tb_firmware_loader.sv
// Scoreboard bench for firmware_loader: expected writes are queued as payload
// bytes are driven and matched (address, data, cycle) when wr_en appears.
module tb_firmware_loader;

    typedef logic [7:0] byte_q_t[$];

    typedef struct {
        logic [13:0] addr;
        logic [7:0]  data;
        int          cyc;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests_run = 0;
    int   tests_failed = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    wr_t  exp_q[$];
    wr_t  e;

    firmware_loader_if bus();

    firmware_loader dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.done === 1'b1) done_cnt++;
        if (bus.wr_en === 1'b1) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_write addr=%h data=%h cyc=%0d", bus.wr_address, bus.wr_data, cyc);
            end else begin
                e = exp_q.pop_front();
                if (bus.wr_address !== e.addr || bus.wr_data !== e.data || cyc !== e.cyc) begin
                    tests_failed++;
                    $display("FAIL write got addr=%h data=%h cyc=%0d expected addr=%h data=%h cyc=%0d",
                             bus.wr_address, bus.wr_data, cyc, e.addr, e.data, e.cyc);
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit payload, input logic [13:0] a);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tests_run++;
        if (bus.rx_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rx_ready got %b expected 1", bus.rx_ready);
        end
        @(posedge clk);
        #1;
        if (payload) exp_q.push_back('{a, b, cyc});
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] flags, input logic [15:0] addr,
                              input logic [15:0] len, input byte_q_t pl,
                              input bit bad, input int gap);
        logic [7:0] sum;
        logic [7:0] csum;
        sum = flags + addr[15:8] + addr[7:0] + len[15:8] + len[7:0];
        send_byte(8'hA5, 1'b0, 14'd0);
        send_byte(flags, 1'b0, 14'd0);
        send_byte(addr[15:8], 1'b0, 14'd0);
        send_byte(addr[7:0], 1'b0, 14'd0);
        send_byte(len[15:8], 1'b0, 14'd0);
        send_byte(len[7:0], 1'b0, 14'd0);
        for (int i = 0; i < pl.size(); i++) begin
            sum = sum + pl[i];
            send_byte(pl[i], 1'b1, 14'(addr + 16'(i)));
            if (gap > 0 && i < pl.size() - 1) idle(gap);
        end
        csum = 8'h00 - sum;
        if (bad) csum = csum + 8'h01;
        send_byte(csum, 1'b0, 14'd0);
    endtask

    task automatic check_drained(input string name);
        idle(3);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL %s missing_writes got %0d pending expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        rst_n = 1'b0;
        idle(2);
        tests_run++;
        if (bus.rx_ready !== 1'b0 || bus.wr_en !== 1'b0 || bus.wr_address !== 14'd0 ||
            bus.wr_data !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.err !== 1'b0 || bus.cpu_hold !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_values got rdy=%b we=%b a=%h d=%h busy=%b done=%b err=%b hold=%b expected 0 0 0 0 0 0 0 1",
                     bus.rx_ready, bus.wr_en, bus.wr_address, bus.wr_data, bus.busy, bus.done, bus.err, bus.cpu_hold);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        tests_run++;
        if (bus.rx_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL ready_after_reset got %b expected 1", bus.rx_ready);
        end
    endtask

    task automatic test_bad_csum();
        int d0;
        d0 = done_cnt;
        send_frame(8'h01, 16'h0010, 16'd3, '{8'h11, 8'h22, 8'h33}, 1'b1, 0);
        tests_run++;
        if (bus.err !== 1'b1 || bus.done !== 1'b0 || bus.cpu_hold !== 1'b1 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL bad_csum got err=%b done=%b hold=%b busy=%b expected 1 0 1 0",
                     bus.err, bus.done, bus.cpu_hold, bus.busy);
        end
        check_drained("bad_csum");
        tests_run++;
        if (done_cnt !== d0) begin
            tests_failed++;
            $display("FAIL bad_csum_done_pulses got %0d expected 0", done_cnt - d0);
        end
    endtask

    task automatic test_bounds_reject();
        logic [15:0] addrs[3] = '{16'h2FFF, 16'h3000, 16'h0010};
        logic [15:0] lens[3]  = '{16'd2, 16'd1, 16'd0};
        for (int k = 0; k < 3; k++) begin
            send_byte(8'hA5, 1'b0, 14'd0);
            send_byte(8'h00, 1'b0, 14'd0);
            send_byte(addrs[k][15:8], 1'b0, 14'd0);
            send_byte(addrs[k][7:0], 1'b0, 14'd0);
            send_byte(lens[k][15:8], 1'b0, 14'd0);
            send_byte(lens[k][7:0], 1'b0, 14'd0);
            tests_run++;
            if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL reject_%0d got err=%b busy=%b expected 1 0", k, bus.err, bus.busy);
            end
            send_byte(8'h11, 1'b0, 14'd0);
            check_drained("reject");
        end
        send_frame(8'h00, 16'h0020, 16'd2, '{8'hC3, 8'h3C}, 1'b0, 0);
        tests_run++;
        if (bus.err !== 1'b0 || bus.done !== 1'b1) begin
            tests_failed++;
            $display("FAIL reject_recover got err=%b done=%b expected 0 1", bus.err, bus.done);
        end
        check_drained("reject_recover");
    endtask

    task automatic test_edge_address();
        send_frame(8'h00, 16'h2FFF, 16'd1, '{8'h5A}, 1'b0, 0);
        tests_run++;
        if (bus.done !== 1'b1 || bus.err !== 1'b0 || bus.cpu_hold !== 1'b1) begin
            tests_failed++;
            $display("FAIL edge_address got done=%b err=%b hold=%b expected 1 0 1", bus.done, bus.err, bus.cpu_hold);
        end
        idle(1);
        tests_run++;
        if (bus.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL done_width got %b expected 0", bus.done);
        end
        check_drained("edge_address");
    endtask

    task automatic test_resync_gaps();
        send_byte(8'h00, 1'b0, 14'd0);
        send_byte(8'hFF, 1'b0, 14'd0);
        send_frame(8'h00, 16'h00A5, 16'd4, '{8'h01, 8'hA5, 8'h7E, 8'h80}, 1'b0, 3);
        tests_run++;
        if (bus.done !== 1'b1 || bus.err !== 1'b0) begin
            tests_failed++;
            $display("FAIL resync_gaps got done=%b err=%b expected 1 0", bus.done, bus.err);
        end
        check_drained("resync_gaps");
    endtask

    task automatic test_max_frame();
        byte_q_t pl;
        for (int i = 0; i < 'h3000; i++) pl.push_back(8'(i) ^ 8'h3C);
        send_frame(8'h00, 16'h0000, 16'h3000, pl, 1'b0, 0);
        tests_run++;
        if (bus.done !== 1'b1 || bus.err !== 1'b0 || bus.wr_address !== 14'h2FFF) begin
            tests_failed++;
            $display("FAIL max_frame got done=%b err=%b last_addr=%h expected 1 0 2fff",
                     bus.done, bus.err, bus.wr_address);
        end
        check_drained("max_frame");
    endtask

    task automatic test_reset_mid_payload();
        send_byte(8'hA5, 1'b0, 14'd0);
        send_byte(8'h01, 1'b0, 14'd0);
        send_byte(8'h02, 1'b0, 14'd0);
        send_byte(8'h00, 1'b0, 14'd0);
        send_byte(8'h00, 1'b0, 14'd0);
        send_byte(8'h03, 1'b0, 14'd0);
        send_byte(8'h44, 1'b0, 14'd0);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus.rx_ready !== 1'b0 || bus.wr_en !== 1'b0 || bus.wr_address !== 14'd0 ||
            bus.wr_data !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.err !== 1'b0 || bus.cpu_hold !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_reset got rdy=%b we=%b a=%h d=%h busy=%b done=%b err=%b hold=%b expected 0 0 0 0 0 0 0 1",
                     bus.rx_ready, bus.wr_en, bus.wr_address, bus.wr_data, bus.busy, bus.done, bus.err, bus.cpu_hold);
        end
        idle(2);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        send_frame(8'h00, 16'h0200, 16'd3, '{8'h44, 8'h55, 8'h66}, 1'b0, 0);
        tests_run++;
        if (bus.done !== 1'b1 || bus.err !== 1'b0) begin
            tests_failed++;
            $display("FAIL after_mid_reset got done=%b err=%b expected 1 0", bus.done, bus.err);
        end
        check_drained("after_mid_reset");
    endtask

    task automatic test_good_final();
        int d0;
        d0 = done_cnt;
        send_byte(8'hA5, 1'b0, 14'd0);
        tests_run++;
        if (bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL busy_after_sync got %b expected 1", bus.busy);
        end
        send_byte(8'h01, 1'b0, 14'd0);
        send_byte(8'h00, 1'b0, 14'd0);
        send_byte(8'h10, 1'b0, 14'd0);
        send_byte(8'h00, 1'b0, 14'd0);
        send_byte(8'h03, 1'b0, 14'd0);
        send_byte(8'h11, 1'b1, 14'h0010);
        send_byte(8'h22, 1'b1, 14'h0011);
        send_byte(8'h33, 1'b1, 14'h0012);
        tests_run++;
        if (bus.cpu_hold !== 1'b1) begin
            tests_failed++;
            $display("FAIL hold_before_csum got %b expected 1", bus.cpu_hold);
        end
        send_byte(8'h86, 1'b0, 14'd0);
        tests_run++;
        if (bus.done !== 1'b1 || bus.cpu_hold !== 1'b0 || bus.err !== 1'b0 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL good_final got done=%b hold=%b err=%b busy=%b expected 1 0 0 0",
                     bus.done, bus.cpu_hold, bus.err, bus.busy);
        end
        check_drained("good_final");
        tests_run++;
        if (done_cnt !== d0 + 1) begin
            tests_failed++;
            $display("FAIL good_final_done_pulses got %0d expected 1", done_cnt - d0);
        end
        send_frame(8'h00, 16'h0100, 16'd1, '{8'h99}, 1'b1, 0);
        tests_run++;
        if (bus.cpu_hold !== 1'b0 || bus.err !== 1'b1) begin
            tests_failed++;
            $display("FAIL hold_sticky got hold=%b err=%b expected 0 1", bus.cpu_hold, bus.err);
        end
        check_drained("hold_sticky");
    endtask

    initial begin
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        test_reset();
        test_bad_csum();
        test_bounds_reject();
        test_edge_address();
        test_resync_gaps();
        test_max_frame();
        test_reset_mid_payload();
        test_good_final();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
